obstacle_gen: RTL

- Produces the packed obstacle buses that game_logic consumes for collision checks.
- Keeps 10 obstacle slots. Spawns obstacles at the right screen edge at a pseudo-random height and scrolls them left every in-game cycle.
- Retires each obstacle when it leaves the left edge and counts retired obstacles as a score.
- Sits between the game-mode logic and the collision/render logic, one clk per game frame.

---
 rtl/obstacle_pkg.sv | 23 ++
 rtl/obstacle_gen_lfsr16.sv | 19 +
 rtl/obstacle_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/obstacle_pkg.sv
// Shared constants for the obstacle generator: bus packing, parked-slot
// encoding and game-mode encodings.
package obstacle_pkg;

    localparam int NUM_OBS  = 10;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int X_STRIDE = 2 * X_W;
    localparam int Y_STRIDE = 2 * Y_W;

    localparam logic [X_W-1:0] PARK_X = 10'h3FF;

    localparam int UPPER_BOUND = 20;
    localparam int LOWER_BOUND = 460;

    typedef enum logic [1:0] {
        GM_INIT  = 2'b00,
        GM_PLAY  = 2'b01,
        GM_PAUSE = 2'b10,
        GM_END   = 2'b11
    } gamemode_e;

endpackage

// File: rtl/obstacle_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick
// obstacle heights; advances every clock regardless of game mode.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

endmodule

// File: rtl/obstacle_gen.sv
// Ten-slot obstacle generator: spawns at the right edge, scrolls left, retires
// and scores. Optional macro OBSTACLE_SPEEDUP_EN ramps scroll speed with spawns.
module obstacle_gen #(
    parameter int          SCREEN_W       = 640,
    parameter int          OBS_WIDTH      = 40,
    parameter int          OBS_HEIGHT     = 120,
    parameter int          UPPER_BOUND    = 20,
    parameter int          SPEED          = 4,
    parameter int          SPAWN_INTERVAL = 80,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   gamemode,
    output logic [199:0] obstacle_x,
    output logic [179:0] obstacle_y,
    output logic [9:0]   obstacle_active,
    output logic [15:0]  score
);
    import obstacle_pkg::*;

    localparam int CNT_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SPAWN_INTERVAL - 1);
    localparam int IDX_W = $clog2(NUM_OBS);

    logic [X_W-1:0]     left_q  [NUM_OBS];
    logic [X_W-1:0]     right_q [NUM_OBS];
    logic [Y_W-1:0]     top_q   [NUM_OBS];
    logic [Y_W-1:0]     bot_q   [NUM_OBS];
    logic [NUM_OBS-1:0] active_q;
    logic [NUM_OBS-1:0] retire;
    logic [CNT_W-1:0]   spawn_cnt;
    logic [15:0]        score_q;
    logic [15:0]        lfsr;
    logic [IDX_W-1:0]   free_idx;
    logic               free_found;
    logic               spawn_tick;
    logic [X_W-1:0]     step;
    logic [3:0]         retire_cnt;
    logic [16:0]        score_sum;
    logic [Y_W-1:0]     new_top;
    logic               unused_lfsr_hi;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:8];

`ifdef OBSTACLE_SPEEDUP_EN
    localparam logic [3:0] SPEED_MAX = 4'd12;
    logic [3:0] speed_q;
    logic [2:0] spawn_ok;

    // Speed steps up on every eighth successful spawn, i.e. when spawn_ok wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_q  <= 4'(SPEED);
            spawn_ok <= '0;
        end else if (gamemode == GM_INIT) begin
            speed_q  <= 4'(SPEED);
            spawn_ok <= '0;
        end else if (gamemode == GM_PLAY && spawn_tick && free_found) begin
            spawn_ok <= spawn_ok + 3'd1;
            if (spawn_ok == 3'd7 && speed_q < SPEED_MAX) begin
                speed_q <= speed_q + 4'd1;
            end
        end
    end

    assign step = X_W'(speed_q);
`else
    assign step = X_W'(SPEED);
`endif

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        retire     = '0;
        retire_cnt = '0;
        // Descending scan so the lowest free index wins.
        for (int k = NUM_OBS - 1; k >= 0; k--) begin
            if (!active_q[k]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(k);
            end
        end
        for (int k = 0; k < NUM_OBS; k++) begin
            retire[k]  = active_q[k] && (left_q[k] < step);
            retire_cnt = retire_cnt + 4'(retire[k]);
        end
        spawn_tick = (spawn_cnt == '0);
        score_sum  = {1'b0, score_q} + 17'(retire_cnt);
        new_top    = Y_W'(UPPER_BOUND) + Y_W'(lfsr[7:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OBS; k++) begin
                left_q[k]  <= PARK_X;
                right_q[k] <= PARK_X;
                top_q[k]   <= '0;
                bot_q[k]   <= '0;
            end
            active_q  <= '0;
            spawn_cnt <= CNT_RELOAD;
            score_q   <= '0;
        end else begin
            case (gamemode_e'(gamemode))
                GM_INIT: begin
                    for (int k = 0; k < NUM_OBS; k++) begin
                        left_q[k]  <= PARK_X;
                        right_q[k] <= PARK_X;
                        top_q[k]   <= '0;
                        bot_q[k]   <= '0;
                    end
                    active_q  <= '0;
                    spawn_cnt <= CNT_RELOAD;
                    score_q   <= '0;
                end
                GM_PLAY: begin
                    for (int k = 0; k < NUM_OBS; k++) begin
                        if (retire[k]) begin
                            active_q[k] <= 1'b0;
                            left_q[k]   <= PARK_X;
                            right_q[k]  <= PARK_X;
                            top_q[k]    <= '0;
                            bot_q[k]    <= '0;
                        end else if (active_q[k]) begin
                            left_q[k]  <= left_q[k] - step;
                            right_q[k] <= right_q[k] - step;
                        end
                    end
                    score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    // free_idx comes from the pre-retire mask, so a retiring slot
                    // never collides with the spawn write.
                    if (spawn_tick) begin
                        spawn_cnt <= CNT_RELOAD;
                        if (free_found) begin
                            active_q[free_idx] <= 1'b1;
                            left_q[free_idx]   <= X_W'(SCREEN_W);
                            right_q[free_idx]  <= X_W'(SCREEN_W + OBS_WIDTH);
                            top_q[free_idx]    <= new_top;
                            bot_q[free_idx]    <= new_top + Y_W'(OBS_HEIGHT);
                        end
                    end else begin
                        spawn_cnt <= spawn_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_OBS; k++) begin : g_pack
        assign obstacle_x[k*X_STRIDE +: X_W]       = left_q[k];
        assign obstacle_x[k*X_STRIDE + X_W +: X_W] = right_q[k];
        assign obstacle_y[k*Y_STRIDE +: Y_W]       = top_q[k];
        assign obstacle_y[k*Y_STRIDE + Y_W +: Y_W] = bot_q[k];
    end

    assign obstacle_active = active_q;
    assign score           = score_q;

endmodule
